// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NUM_CH-way valid/ready selector, round-robin or fixed-priority grant, registered output
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_valid  per-channel words and requests; in_ready is the one-hot accept
//   prio_mode         0 = round-robin from ptr, 1 = lowest valid index wins
//   out_data/out_sel  registered word and the channel it came from
//   out_valid/out_ready output handshake
module rr_arb_mux #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     prio_mode,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  input  logic                     out_ready
);
  logic [SEL_W-1:0] ptr, grant;
  logic             load, any, found;
  int               idx;
  assign load = ~out_valid | out_ready;
  assign any  = |in_valid;
  // Scan from ptr (round-robin) or from 0 (fixed priority); first valid hit wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = prio_mode ? k : (int'(ptr) + k) % NUM_CH;
      if (!found && in_valid[idx]) begin
        grant = SEL_W'(idx);
        found = 1'b1;
      end
    end
  end
  assign in_ready = (rst_n && load && any) ? NUM_CH'(1) << grant : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (any) begin
        out_valid <= 1'b1;
        out_data  <= in_data[int'(grant)*DATA_W +: DATA_W];
        out_sel   <= grant;
        if (!prio_mode) ptr <= (grant == SEL_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: randomized and directed check of rr_arb_mux against a distance-based arbitration model
module tb_rr_arb_mux;
  localparam int N = 8;
  localparam int W = 32;
  localparam int S = 3;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid, in_ready;
  logic             prio_mode, out_valid, out_ready;
  logic [W-1:0]     out_data;
  logic [S-1:0]     out_sel;
  int vectors = 0;
  int errors  = 0;
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_sel, m_ptr;
  rr_arb_mux #(.NUM_CH(N), .DATA_W(W), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .prio_mode(prio_mode), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Winner is the valid channel at the smallest distance from the start point.
  function automatic int pick(input logic [N-1:0] v, input bit pm, input int p);
    int best = -1;
    int bd = N;
    for (int i = 0; i < N; i++)
      if (v[i]) begin
        int d = pm ? i : (i - p + N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    return best;
  endfunction
  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = 0; m_ptr = 0;
  endtask
  task automatic set_data(input int i, input logic [W-1:0] v);
    in_data[i*W +: W] = v;
  endtask
  task automatic step();
    int g;
    bit ld;
    logic [N-1:0] er;
    #1;
    ld = !m_valid || out_ready;
    g  = pick(in_valid, prio_mode, m_ptr);
    er = (ld && g >= 0) ? N'(1 << g) : '0;
    chk("in_ready", in_ready, er);
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_valid = 1;
        m_data  = in_data[g*W +: W];
        m_sel   = g;
        if (!prio_mode) m_ptr = (g + 1) % N;
      end else m_valid = 0;
    end
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_sel", out_sel, m_sel);
  endtask
  initial begin
    rst_n = 0; in_valid = '1; prio_mode = 0; out_ready = 1;
    for (int i = 0; i < N; i++) set_data(i, 32'h1000_0000 + i);
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1;
    for (int i = 0; i <= N; i++) begin
      step();
      chk("rr_sel_lit", out_sel, i % N);
      chk("rr_data_lit", out_data, 32'h1000_0000 + (i % N));
    end
    prio_mode = 1; in_valid = 8'b1010_0100;
    for (int i = 0; i < 3; i++) begin step(); chk("fp_ch2_lit", out_sel, 2); end
    in_valid = 8'b1010_0000;
    for (int i = 0; i < 2; i++) begin step(); chk("fp_ch5_lit", out_sel, 5); end
    prio_mode = 0; in_valid = '1;
    step(); chk("rr_resume_lit", out_sel, 1);
    in_valid = 8'b0000_1000; set_data(3, 32'hDEAD_0003);
    step(); chk("bp_load_lit", out_data, 32'hDEAD_0003);
    out_ready = 0; in_valid = 8'b0001_0000; set_data(4, 32'hBEEF_0004);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_lit", out_data, 32'hDEAD_0003);
      chk("bp_ready_lit", in_ready, 0);
    end
    out_ready = 1;
    step(); chk("bp_release_lit", out_data, 32'hBEEF_0004);
    in_valid = 8'b0010_0000;
    step(); chk("wrap_pre_lit", out_sel, 5);
    in_valid = 8'b0000_0011;
    step(); chk("wrap_ch0_lit", out_sel, 0);
    step(); chk("wrap_ch1_lit", out_sel, 1);
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 1) != 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
      prio_mode = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      step();
    end
    in_valid = '1; prio_mode = 0; out_ready = 1;
    step();
    chk("mid_valid_lit", out_valid, 1);
    #1 rst_n = 0;
    #1;
    chk("arst_valid_lit", out_valid, 0);
    chk("arst_data_lit", out_data, 0);
    chk("arst_ready_lit", in_ready, 0);
    model_reset();
    rst_n = 1;
    step(); chk("arst_restart_lit", out_sel, 0);
    step(); chk("arst_next_lit", out_sel, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-channel, valid/ready-handshaked selector with a registered output stage.
- Successor to the fixed 8:1 combinational 32-bit mux. Arbitrates among NUM_CH producers in round-robin or fixed-priority mode and forwards one word per cycle to a single consumer.
- Used in the datapath wherever several sources contend for one sink, e.g. writeback source selection or memory-port sharing.

Parameters:
- NUM_CH, 8, number of input channels (2..16).
- DATA_W, 32, data width per channel.
- SEL_W, 3, width of grant index; must equal ceil(log2(NUM_CH)).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  input  NUM_CH  per-channel request.
- in_ready  output  NUM_CH  per-channel accept; at most one bit high.
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- out_data  output  DATA_W  registered selected word.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  out_data/out_sel hold a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Single clock domain (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. in_ready is combinational and is 0 while rst_n=0.
- load = ~out_valid | out_ready. This is combinational, so a full output register can drain and reload in the same cycle.
- Grant is combinational from in_valid, prio_mode and ptr:
  - Round-robin: the first valid channel scanning ptr, ptr+1, ..., wrapping modulo NUM_CH.
  - Fixed priority: the lowest-index valid channel. ptr is ignored.
- in_ready[g] = load & (some in_valid) & (g == grant). All other in_ready bits are 0.
- Transfer on input i: in_valid[i] & in_ready[i]. On the next rising edge:
  - out_data <= in_data[i];
  - out_sel <= i;
  - out_valid <= 1.
- If load=1 and no in_valid bit is set: out_valid <= 0. out_data and out_sel keep their values.
- Stall: while out_valid & ~out_ready, out_data, out_sel and out_valid are stable and all in_ready are 0.
- Latency is 1 cycle from input transfer to out_valid. Sustained throughput is 1 word/cycle when out_ready=1.
- ptr update happens only on a transfer in round-robin mode: ptr <= (grant == NUM_CH-1) ? 0 : grant+1. Fixed-priority transfers leave ptr unchanged.
- Mode change: prio_mode is sampled combinationally each cycle and takes effect in the same cycle's grant. Switching back to round-robin resumes from the retained ptr.
- Wrap-around: a grant on channel NUM_CH-1 sets ptr to 0.
- Single requester: it is granted every cycle it is valid and load=1, regardless of ptr.
- Producer rule: producers hold in_valid and in_data until accepted. The block must not depend on that rule, because grant is recomputed every cycle.
- Reset mid-operation: asserting rst_n=0 immediately clears out_valid, out_data, out_sel and ptr. Any pending word is dropped.
- No X propagation: out_data only loads from a granted channel.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=8'hFF -> out_valid=0, out_data=0, in_ready=0. Release -> first grant goes to ch0 (ptr=0).
- Round-robin fairness: prio_mode=0, in_valid=8'hFF constant, in_data[i]=32'h1000_0000+i, out_ready=1 -> out_sel sequence 0,1,...,7,0 on consecutive cycles, with out_data matching.
- Fixed priority: prio_mode=1, in_valid=8'b1010_0100 -> ch2 granted every cycle. Drop ch2 -> ch5 granted. ptr stays unchanged throughout.
- Backpressure: out_ready=0 for 3 cycles after a ch3 word is loaded (out_data=32'hDEAD_0003) -> outputs stable, in_ready=0. Raise out_ready with ch4 valid -> ch4 word appears the next cycle with no bubble.
- Wrap and sparse: ptr=6, in_valid=8'b0000_0011 -> ch0 granted, ptr becomes 1. Next cycle ch1 granted, ptr becomes 2.
- Async reset mid-stream: pulse rst_n low between clock edges while out_valid=1 -> out_valid drops immediately. After release, arbitration restarts from ch0.
